// File: rtl/muon_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muon_pkg : state encoding and constants shared by the coincidence/TDC path
// Rev 1.0
// ---------------------------------------------------------------------------
package muon_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_B = 2'd1,
      WAIT_A = 2'd2,
      TIMING = 2'd3
   } state_t;

   localparam int unsigned COUNT_MAX         = 9999;
   localparam int unsigned TICK_DIV_DEF      = 10;
   localparam int unsigned TIMEOUT_TICKS_DEF = 9999;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/coinc_tdc_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// coinc_tdc_if : event pulses in, coincidence count and TDC result out
// Rev 1.0
// ---------------------------------------------------------------------------
interface coinc_tdc_if #(
   parameter int unsigned CNT_W  = 14,
   parameter int unsigned MEAS_W = 14
);
   logic              a_pulse;
   logic              b_pulse;
   logic              c_pulse;
   logic              clr_counts;
   logic              coinc_pulse;
   logic [CNT_W-1:0]  coinc_count;
   logic              busy;
   logic [MEAS_W-1:0] time_measurement;
   logic              meas_valid;
   logic              timeout_flag;

   modport master (
      output a_pulse, b_pulse, c_pulse, clr_counts,
      input  coinc_pulse, coinc_count, busy, time_measurement, meas_valid, timeout_flag
   );

   modport slave (
      input  a_pulse, b_pulse, c_pulse, clr_counts,
      output coinc_pulse, coinc_count, busy, time_measurement, meas_valid, timeout_flag
   );
endinterface
`default_nettype wire

// File: rtl/tdc_prescaler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tdc_prescaler : one-cycle tick every TICK_DIV enabled clk cycles
// Rev 1.0
// ---------------------------------------------------------------------------
module tdc_prescaler
   import muon_pkg::*;
#(
   parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
   input  wire  clk,
   input  wire  rst_n,
   input  wire  i_clr,
   input  wire  i_en,
   output logic o_tick
);

   localparam int unsigned c_pw = cnt_width(TICK_DIV - 1);
   localparam logic [c_pw-1:0] c_last = c_pw'(TICK_DIV - 1);

   logic [c_pw-1:0] r_cnt;
   logic            w_wrap;

   assign w_wrap = (r_cnt == c_last);

   always_ff @(posedge clk) begin
      if (!rst_n || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_tick = i_en & w_wrap;

endmodule
`default_nettype wire

// File: rtl/coinc_tdc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// coinc_tdc : A/B coincidence detector feeding a C-stopped time-to-digital converter
// Rev 1.0
// ---------------------------------------------------------------------------
module coinc_tdc
   import muon_pkg::*;
#(
   parameter int unsigned COINC_WIN     = 16,
   parameter int unsigned TICK_DIV      = TICK_DIV_DEF,
   parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
   parameter int unsigned MEAS_W        = 14,
   parameter int unsigned CNT_W         = 14
) (
   input  wire        clk,
   input  wire        rst_n,
   coinc_tdc_if.slave bus
);

   localparam int unsigned c_ww = cnt_width(COINC_WIN);
   localparam logic [c_ww-1:0]   c_win      = c_ww'(COINC_WIN);
   localparam logic [MEAS_W-1:0] c_to       = MEAS_W'(TIMEOUT_TICKS);
   localparam logic [MEAS_W-1:0] c_to_last  = MEAS_W'(TIMEOUT_TICKS - 1);
   localparam logic [CNT_W-1:0]  c_cnt_max  = CNT_W'(COUNT_MAX);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [c_ww-1:0]   r_win;
   logic [MEAS_W-1:0] r_ticks;
   logic [CNT_W-1:0]  r_count;
   logic [MEAS_W-1:0] r_meas;
   logic              r_timeout;
   logic              r_coinc_pulse;
   logic              r_meas_valid;

   logic w_coinc;
   logic w_win_clr;
   logic w_win_inc;
   logic w_stop;
   logic w_timeout;
   logic w_tick;

   tdc_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_coinc),
      .i_en   (r_state == TIMING),
      .o_tick (w_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_coinc     = 1'b0;
      w_win_clr   = 1'b0;
      w_win_inc   = 1'b0;
      w_stop      = 1'b0;
      w_timeout   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.a_pulse && bus.b_pulse) begin
               w_coinc     = 1'b1;
               w_state_nxt = TIMING;
            end else if (bus.a_pulse) begin
               w_win_clr   = 1'b1;
               w_state_nxt = WAIT_B;
            end else if (bus.b_pulse) begin
               w_win_clr   = 1'b1;
               w_state_nxt = WAIT_A;
            end
         end
         WAIT_B: begin
            if (bus.b_pulse && (r_win < c_win)) begin
               w_coinc     = 1'b1;
               w_state_nxt = TIMING;
            end else if (bus.a_pulse) begin
               w_win_clr   = 1'b1;
            end else if (r_win >= c_win) begin
               w_state_nxt = IDLE;
            end else begin
               w_win_inc   = 1'b1;
            end
         end
         WAIT_A: begin
            if (bus.a_pulse && (r_win < c_win)) begin
               w_coinc     = 1'b1;
               w_state_nxt = TIMING;
            end else if (bus.b_pulse) begin
               w_win_clr   = 1'b1;
            end else if (r_win >= c_win) begin
               w_state_nxt = IDLE;
            end else begin
               w_win_inc   = 1'b1;
            end
         end
         TIMING: begin
            // A stop in the timeout-tick cycle wins and reports the pre-increment count.
            if (bus.c_pulse) begin
               w_stop      = 1'b1;
               w_state_nxt = IDLE;
            end else if (w_tick && (r_ticks == c_to_last)) begin
               w_timeout   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_win         <= '0;
         r_ticks       <= '0;
         r_coinc_pulse <= 1'b0;
         r_meas_valid  <= 1'b0;
      end else begin
         r_coinc_pulse <= w_coinc;
         r_meas_valid  <= w_stop | w_timeout;
         if (w_win_clr) begin
            r_win <= '0;
         end else if (w_win_inc) begin
            r_win <= r_win + 1'b1;
         end
         if (w_coinc) begin
            r_ticks <= '0;
         end else if (w_tick && !w_stop && !w_timeout) begin
            r_ticks <= r_ticks + 1'b1;
         end
      end
   end

   // Clear beats a simultaneous coincidence; a completing measurement beats the clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count   <= '0;
         r_meas    <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (bus.clr_counts) begin
            r_count <= '0;
         end else if (w_coinc && (r_count != c_cnt_max)) begin
            r_count <= r_count + 1'b1;
         end
         if (w_stop) begin
            r_meas    <= r_ticks;
            r_timeout <= 1'b0;
         end else if (w_timeout) begin
            r_meas    <= c_to;
            r_timeout <= 1'b1;
         end else if (bus.clr_counts) begin
            r_meas    <= '0;
            r_timeout <= 1'b0;
         end
      end
   end

   assign bus.coinc_pulse      = r_coinc_pulse;
   assign bus.coinc_count      = r_count;
   assign bus.busy             = (r_state == TIMING);
   assign bus.time_measurement = r_meas;
   assign bus.meas_valid       = r_meas_valid;
   assign bus.timeout_flag     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_coinc_tdc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_coinc_tdc : directed stimulus with queued expectations checked by output monitors
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_coinc_tdc;

   typedef struct {
      int tm;
      int fl;
   } meas_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   cc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;

   int    exp_coinc[$];
   int    exp_coinc_l[$];
   meas_t exp_meas[$];
   meas_t exp_meas_l[$];
   int    ec;
   int    ec_l;
   meas_t em;
   meas_t em_l;

   coinc_tdc_if #(.CNT_W(14), .MEAS_W(14)) bus ();
   coinc_tdc_if #(.CNT_W(14), .MEAS_W(14)) bus_l ();

   coinc_tdc #(
      .COINC_WIN(16), .TICK_DIV(10), .TIMEOUT_TICKS(100), .MEAS_W(14), .CNT_W(14)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   // Longer timeout instance, used only for the full-length stopped measurement.
   coinc_tdc #(
      .COINC_WIN(16), .TICK_DIV(10), .TIMEOUT_TICKS(1000), .MEAS_W(14), .CNT_W(14)
   ) dut_l (
      .clk(clk), .rst_n(rst_n), .bus(bus_l)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL unexpected %s: got 1, required 0 (cycle %0d)", name, cyc);
   endtask

   task automatic report();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input bit lng, input bit a, input bit b, input bit c, input bit clr);
      if (lng) begin
         bus_l.a_pulse = a; bus_l.b_pulse = b; bus_l.c_pulse = c; bus_l.clr_counts = clr;
      end else begin
         bus.a_pulse = a; bus.b_pulse = b; bus.c_pulse = c; bus.clr_counts = clr;
      end
      @(posedge clk);
      #1;
      bus.a_pulse = 1'b0;   bus.b_pulse = 1'b0;   bus.c_pulse = 1'b0;   bus.clr_counts = 1'b0;
      bus_l.a_pulse = 1'b0; bus_l.b_pulse = 1'b0; bus_l.c_pulse = 1'b0; bus_l.clr_counts = 1'b0;
   endtask

   // Simultaneous A/B coincidence; cc marks the edge that sampled it.
   task automatic coinc(input bit lng, input int exp_cnt, input bit clr);
      if (lng) exp_coinc_l.push_back(exp_cnt);
      else     exp_coinc.push_back(exp_cnt);
      drive(lng, 1'b1, 1'b1, 1'b0, clr);
      cc = cyc;
   endtask

   // C sampled k cycles after the coinc_pulse cycle: captured ticks = k / TICK_DIV.
   task automatic stop_at(input bit lng, input int k, input int exp_tm);
      meas_t m;
      m.tm = exp_tm;
      m.fl = 0;
      if (lng) exp_meas_l.push_back(m);
      else     exp_meas.push_back(m);
      wait_until(cc + k);
      drive(lng, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " coinc_pulse"},      32'(bus.coinc_pulse), 32'd0);
      chk({tag, " coinc_count"},      32'(bus.coinc_count), 32'd0);
      chk({tag, " busy"},             32'(bus.busy), 32'd0);
      chk({tag, " time_measurement"}, 32'(bus.time_measurement), 32'd0);
      chk({tag, " meas_valid"},       32'(bus.meas_valid), 32'd0);
      chk({tag, " timeout_flag"},     32'(bus.timeout_flag), 32'd0);
   endtask

   always @(negedge clk) begin
      if (mon_en && bus.coinc_pulse === 1'b1) begin
         if (exp_coinc.size() == 0) unexpected("coinc_pulse");
         else begin
            ec = exp_coinc.pop_front();
            chk("coinc_count", 32'(bus.coinc_count), 32'(ec));
            chk("busy on coinc", 32'(bus.busy), 32'd1);
         end
      end
      if (mon_en && bus.meas_valid === 1'b1) begin
         if (exp_meas.size() == 0) unexpected("meas_valid");
         else begin
            em = exp_meas.pop_front();
            chk("time_measurement", 32'(bus.time_measurement), 32'(em.tm));
            chk("timeout_flag", 32'(bus.timeout_flag), 32'(em.fl));
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en && bus_l.coinc_pulse === 1'b1) begin
         if (exp_coinc_l.size() == 0) unexpected("long coinc_pulse");
         else begin
            ec_l = exp_coinc_l.pop_front();
            chk("long coinc_count", 32'(bus_l.coinc_count), 32'(ec_l));
         end
      end
      if (mon_en && bus_l.meas_valid === 1'b1) begin
         if (exp_meas_l.size() == 0) unexpected("long meas_valid");
         else begin
            em_l = exp_meas_l.pop_front();
            chk("long time_measurement", 32'(bus_l.time_measurement), 32'(em_l.tm));
            chk("long timeout_flag", 32'(bus_l.timeout_flag), 32'(em_l.fl));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
      n_cmp++;
      n_err++;
      report();
      $finish;
   end

   initial begin
      bus.a_pulse = 1'b0;   bus.b_pulse = 1'b0;   bus.c_pulse = 1'b0;   bus.clr_counts = 1'b0;
      bus_l.a_pulse = 1'b0; bus_l.b_pulse = 1'b0; bus_l.c_pulse = 1'b0; bus_l.clr_counts = 1'b0;

      // Reset and idle behaviour
      rst_n = 1'b0;
      idle(5);
      rst_n = 1'b1;
      mon_en = 1'b1;
      check_zero("reset");
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);
      chk("busy after lone C", 32'(bus.busy), 32'd0);

      // B five cycles after A
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);
      exp_coinc.push_back(1);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cc = cyc;
      idle(2);
      chk("busy while timing", 32'(bus.busy), 32'd1);
      stop_at(1'b0, 25, 2);
      idle(2);
      chk("busy after stop", 32'(bus.busy), 32'd0);

      // B twenty cycles after A misses, then opens WAIT_A for a following A
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(19);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      exp_coinc.push_back(2);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cc = cyc;
      stop_at(1'b0, 50, 5);
      idle(2);

      // Window edge: 16 cycles apart counts, 17 does not
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(15);
      exp_coinc.push_back(3);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cc = cyc;
      stop_at(1'b0, 9, 0);
      idle(2);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(16);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(20);
      chk("count after late B", 32'(bus.coinc_count), 32'd3);

      // Simultaneous A&B, then A/B during TIMING are ignored
      coinc(1'b0, 4, 1'b0);
      idle(3);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(3);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("count with A/B in TIMING", 32'(bus.coinc_count), 32'd4);
      stop_at(1'b0, 30, 3);
      idle(2);

      // Full 1000-cycle stopped measurement on the long-timeout instance
      coinc(1'b1, 1, 1'b0);
      stop_at(1'b1, 1000, 100);
      idle(2);
      chk("long busy after stop", 32'(bus_l.busy), 32'd0);

      // Timeout, then a stopped measurement clears the flag
      coinc(1'b0, 5, 1'b0);
      em.tm = 100;
      em.fl = 1;
      exp_meas.push_back(em);
      wait_until(cc + 1005);
      chk("timeout_flag held", 32'(bus.timeout_flag), 32'd1);
      chk("busy after timeout", 32'(bus.busy), 32'd0);
      coinc(1'b0, 6, 1'b0);
      stop_at(1'b0, 75, 7);
      idle(2);
      chk("timeout_flag cleared", 32'(bus.timeout_flag), 32'd0);

      // C in the timeout-tick cycle wins
      coinc(1'b0, 7, 1'b0);
      stop_at(1'b0, 999, 99);
      idle(2);

      // clr_counts together with a coincidence
      coinc(1'b0, 0, 1'b1);
      idle(1);
      chk("tm after clr", 32'(bus.time_measurement), 32'd0);
      chk("busy after clr+coinc", 32'(bus.busy), 32'd1);
      stop_at(1'b0, 12, 1);
      idle(2);

      // Reset at tick 50 aborts silently
      coinc(1'b0, 1, 1'b0);
      wait_until(cc + 505);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      check_zero("mid-timing reset");
      idle(1100);

      // Back-to-back coincidences drive the count into saturation
      for (int i = 1; i <= 10000; i++) begin
         coinc(1'b0, (i > 9999) ? 9999 : i, 1'b0);
         stop_at(1'b0, 0, 0);
      end
      idle(5);
      chk("saturated coinc_count", 32'(bus.coinc_count), 32'd9999);

      chk("coinc queue drained", 32'(exp_coinc.size()), 32'd0);
      chk("meas queue drained", 32'(exp_meas.size()), 32'd0);
      chk("long coinc queue drained", 32'(exp_coinc_l.size()), 32'd0);
      chk("long meas queue drained", 32'(exp_meas_l.size()), 32'd0);
      report();
      $finish;
   end

endmodule
`default_nettype wire
